alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//   Parametrised, registered ALU operand stage for the pipelined core. Selects operand1
//   (rs1/PC/zero) and operand2 (rs2/immediate/constant 4), resolves RAW hazards by
//   forwarding from EX and WB, and detects load-use hazards. Results are held in one
//   pipeline register with a valid/ready handshake. Sits between the register file
//   read port and the ALU.
// PARAMETERS
//   XLEN    32  datapath width in bits
//   RAW     5   register address width
//   FWD_EN  1   1: forwarding enabled; 0: no forwarding, every RAW match stalls
// PORTS
//   clk           in   1     rising-edge clock
//   rst_n         in   1     asynchronous reset, active low
//   in_valid      in   1     upstream holds a valid decoded instruction
//   in_ready      out  1     stage accepts the instruction this cycle
//   in_rs1_addr   in   RAW   source register 1 index
//   in_rs2_addr   in   RAW   source register 2 index
//   in_rs1_data   in   XLEN  register file data for rs1
//   in_rs2_data   in   XLEN  register file data for rs2
//   in_imm        in   XLEN  sign-extended immediate
//   in_pc         in   XLEN  instruction PC
//   in_a_sel      in   2     operand1 select: 0 rs1, 1 PC, 2 zero, 3 rs1
//   in_b_sel      in   2     operand2 select: 0 rs2, 1 imm, 2 constant 4, 3 rs2
//   ex_wr_en/ex_rd/ex_result/ex_is_load  in  1/RAW/XLEN/1  EX-stage writeback info
//   wb_wr_en/wb_rd/wb_result             in  1/RAW/XLEN    WB-stage writeback info
//   out_valid     out  1     registered operands are valid
//   out_ready     in   1     ALU consumes the operands this cycle
//   out_operand1  out  XLEN  registered operand1
//   out_operand2  out  XLEN  registered operand2
//   out_store_data out XLEN  registered forwarded rs2 value (store data)
//   hazard_stall  out  1     combinational: load-use (or no-forward) stall this cycle
// BEHAVIOUR
//   Reset (rst_n low, async): out_valid=0, out_operand1/2=0, out_store_data=0.
//   Forwarding per source s (rs1, rs2), FWD_EN=1:
//     - s_addr==0 -> value 0, never forwarded, never stalls.
//     - ex_wr_en && ex_rd==s_addr && !ex_is_load -> ex_result (EX priority over WB).
//     - else wb_wr_en && wb_rd==s_addr -> wb_result; else in_sN_data.
//   A source is "used": rs1 when in_a_sel in {0,3}; rs2 always (store data).
//   hazard_stall = in_valid && used source s!=0 matches ex_rd with ex_wr_en && ex_is_load.
//     FWD_EN=0: hazard_stall also on any used-source match with EX or WB write.
//   in_ready = !hazard_stall && (!out_valid || out_ready).
//   Capture when in_valid && in_ready: operands latched, out_valid<=1 next edge. Latency 1.
//   out_valid && out_ready with no capture -> out_valid<=0.
//   out_valid && !out_ready -> outputs held stable, in_ready=0 (no overwrite).
//   Stall cycle: nothing captured; if the ALU consumes the old entry, out_valid<=0 (bubble).
//   in_valid low: no capture, regardless of in_ready.
//   Operand2 constant 4 = XLEN-wide value 4. All arithmetic is selection only, no wrap.
//   Reset asserted mid-transfer: entry dropped, outputs return to reset values at once.
// TESTING
//   1. a_sel=0,b_sel=1, rs1=x5 data 0x10, imm 0xFFFFFFF0, no writes -> next cycle
//      out_valid=1, op1=0x10, op2=0xFFFFFFF0.
//   2. rs1=x3; ex_wr_en=1, ex_rd=3, ex_result=0xAA; wb_rd=3, wb_result=0xBB ->
//      op1=0xAA (EX wins); repeat with ex_wr_en=0 -> op1=0xBB.
//   3. rs2=x7, ex_rd=7, ex_is_load=1 -> hazard_stall=1, in_ready=0, no capture; next
//      cycle ex_is_load=0, wb_rd=7, wb_result=0x55 -> capture, store_data=0x55.
//   4. rs1=x0 with ex_rd=0 write 0x99 -> op1=0, no stall; b_sel=2 -> op2=4.
//   5. out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0;
//      out_ready=1 -> new entry captured the same edge, back-to-back throughput 1/cycle.
//   6. Assert rst_n low while out_valid=1 -> out_valid=0 immediately, operands 0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Registered ALU operand stage: operand select, EX/WB forwarding, load-use stall detection
// and a single valid/ready pipeline register in front of the ALU.
module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int RAW    = 5,
  parameter int FWD_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RAW-1:0]  in_rs1_addr,
  input  logic [RAW-1:0]  in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [1:0]      in_a_sel,
  input  logic [1:0]      in_b_sel,
  input  logic            ex_wr_en,
  input  logic [RAW-1:0]  ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ex_is_load,
  input  logic            wb_wr_en,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_operand1,
  output logic [XLEN-1:0] out_operand2,
  output logic [XLEN-1:0] out_store_data,
  output logic            hazard_stall
);

  localparam logic [XLEN-1:0] CONST_FOUR = {{(XLEN-3){1'b0}}, 3'b100};

  logic            rs1_zero;
  logic            rs2_zero;
  logic            ex_hit1;
  logic            ex_hit2;
  logic            wb_hit1;
  logic            wb_hit2;
  logic            rs1_used;
  logic            load_stall;
  logic            nofwd_stall;
  logic            capture;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] op1_next;
  logic [XLEN-1:0] op2_next;

  // x0 never matches a writer, so it can neither forward nor stall
  assign rs1_zero = (in_rs1_addr == '0);
  assign rs2_zero = (in_rs2_addr == '0);
  assign ex_hit1  = ex_wr_en && (ex_rd == in_rs1_addr) && !rs1_zero;
  assign ex_hit2  = ex_wr_en && (ex_rd == in_rs2_addr) && !rs2_zero;
  assign wb_hit1  = wb_wr_en && (wb_rd == in_rs1_addr) && !rs1_zero;
  assign wb_hit2  = wb_wr_en && (wb_rd == in_rs2_addr) && !rs2_zero;
  assign rs1_used = (in_a_sel == 2'd0) || (in_a_sel == 2'd3);

  always_comb begin
    rs1_val = in_rs1_data;
    if (rs1_zero) begin
      rs1_val = '0;
    end else if ((FWD_EN != 0) && ex_hit1 && !ex_is_load) begin
      rs1_val = ex_result;
    end else if ((FWD_EN != 0) && wb_hit1) begin
      rs1_val = wb_result;
    end
  end

  always_comb begin
    rs2_val = in_rs2_data;
    if (rs2_zero) begin
      rs2_val = '0;
    end else if ((FWD_EN != 0) && ex_hit2 && !ex_is_load) begin
      rs2_val = ex_result;
    end else if ((FWD_EN != 0) && wb_hit2) begin
      rs2_val = wb_result;
    end
  end

  // rs2 always counts as used because it doubles as store data
  assign load_stall  = (rs1_used && ex_hit1 && ex_is_load) || (ex_hit2 && ex_is_load);
  assign nofwd_stall = (FWD_EN == 0) &&
                       ((rs1_used && (ex_hit1 || wb_hit1)) || ex_hit2 || wb_hit2);
  assign hazard_stall = in_valid && (load_stall || nofwd_stall);

  assign in_ready = !hazard_stall && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;

  always_comb begin
    op1_next = rs1_val;
    case (in_a_sel)
      2'd1:    op1_next = in_pc;
      2'd2:    op1_next = '0;
      default: op1_next = rs1_val;
    endcase
  end

  always_comb begin
    op2_next = rs2_val;
    case (in_b_sel)
      2'd1:    op2_next = in_imm;
      2'd2:    op2_next = CONST_FOUR;
      default: op2_next = rs2_val;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_operand1   <= '0;
      out_operand2   <= '0;
      out_store_data <= '0;
    end else if (capture) begin
      out_valid      <= 1'b1;
      out_operand1   <= op1_next;
      out_operand2   <= op2_next;
      out_store_data <= rs2_val;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: vector table plus hand-written sequences,
// with a scoreboard queue compared whenever the ALU side consumes an entry.
module tb_alu_operand_stage;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic        ex_wr;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        ex_ld;
    logic        wb_wr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] es;
  } vec_t;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] st;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr;
  logic [4:0]  in_rs2_addr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [1:0]  in_a_sel;
  logic [1:0]  in_b_sel;
  logic        ex_wr_en;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic        wb_wr_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand1;
  logic [31:0] out_operand2;
  logic [31:0] out_store_data;
  logic        hazard_stall;

  int   checks;
  int   failures;
  exp_t sb[$];
  vec_t vecs[8];

  alu_operand_stage #(.XLEN(32), .RAW(5), .FWD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_result(ex_result), .ex_is_load(ex_is_load),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operand1(out_operand1), .out_operand2(out_operand2),
    .out_store_data(out_store_data), .hazard_stall(hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2,
    input logic [31:0] imm, input logic [31:0] pc, input logic [1:0] a_sel, input logic [1:0] b_sel,
    input logic ex_wr, input logic [4:0] ex_rd_i, input logic [31:0] ex_res, input logic ex_ld,
    input logic wb_wr, input logic [4:0] wb_rd_i, input logic [31:0] wb_res,
    input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] es);
    vec_t v;
    v.rs1 = rs1;  v.rs2 = rs2;  v.d1 = d1;  v.d2 = d2;  v.imm = imm;  v.pc = pc;
    v.a_sel = a_sel;  v.b_sel = b_sel;
    v.ex_wr = ex_wr;  v.ex_rd = ex_rd_i;  v.ex_res = ex_res;  v.ex_ld = ex_ld;
    v.wb_wr = wb_wr;  v.wb_rd = wb_rd_i;  v.wb_res = wb_res;
    v.e1 = e1;  v.e2 = e2;  v.es = es;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    in_rs1_addr = v.rs1;   in_rs2_addr = v.rs2;
    in_rs1_data = v.d1;    in_rs2_data = v.d2;
    in_imm      = v.imm;   in_pc       = v.pc;
    in_a_sel    = v.a_sel; in_b_sel    = v.b_sel;
    ex_wr_en    = v.ex_wr; ex_rd       = v.ex_rd;
    ex_result   = v.ex_res; ex_is_load = v.ex_ld;
    wb_wr_en    = v.wb_wr; wb_rd       = v.wb_rd;
    wb_result   = v.wb_res;
  endtask

  // Called just after a rising edge; returns once the entry is accepted or the wait expires.
  task automatic applyStimulus(input vec_t v, output int waited);
    exp_t e;
    driveInputs(v);
    in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 20) begin
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout actual=no_accept expected=accept");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    e.op1 = v.e1;
    e.op2 = v.e2;
    e.st  = v.es;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_unexpected actual=out_valid expected=no_entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_op1", out_operand1, e.op1);
        checkOutput("sb_op2", out_operand2, e.op2);
        checkOutput("sb_store", out_store_data, e.st);
      end
    end
  end

  initial begin
    int w;
    vec_t lu;
    checks = 0;
    failures = 0;

    vecs[0] = mk(5'd5, 5'd6, 32'h10, 32'h20, 32'hFFFF_FFF0, 32'h100, 2'd0, 2'd1,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                 32'h10, 32'hFFFF_FFF0, 32'h20);
    vecs[1] = mk(5'd3, 5'd4, 32'h33, 32'h44, 32'h0, 32'h0, 2'd0, 2'd0,
                 1'b1, 5'd3, 32'hAA, 1'b0, 1'b1, 5'd3, 32'hBB,
                 32'hAA, 32'h44, 32'h44);
    vecs[2] = mk(5'd3, 5'd4, 32'h33, 32'h44, 32'h0, 32'h0, 2'd0, 2'd0,
                 1'b0, 5'd3, 32'hAA, 1'b0, 1'b1, 5'd3, 32'hBB,
                 32'hBB, 32'h44, 32'h44);
    vecs[3] = mk(5'd0, 5'd9, 32'h12, 32'h90, 32'h0, 32'h0, 2'd0, 2'd2,
                 1'b1, 5'd0, 32'h99, 1'b0, 1'b0, 5'd0, 32'h0,
                 32'h0, 32'h4, 32'h90);
    vecs[4] = mk(5'd1, 5'd8, 32'h11, 32'h80, 32'h0, 32'h200, 2'd1, 2'd3,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd8, 32'h77,
                 32'h200, 32'h77, 32'h77);
    vecs[5] = mk(5'd5, 5'd2, 32'h50, 32'h22, 32'h8, 32'h0, 2'd2, 2'd1,
                 1'b1, 5'd5, 32'h66, 1'b1, 1'b0, 5'd0, 32'h0,
                 32'h0, 32'h8, 32'h22);
    vecs[6] = mk(5'd10, 5'd11, 32'h1A, 32'hBB, 32'h0, 32'h0, 2'd3, 2'd2,
                 1'b1, 5'd10, 32'hCC, 1'b0, 1'b1, 5'd10, 32'hDD,
                 32'hCC, 32'h4, 32'hBB);
    vecs[7] = mk(5'd0, 5'd0, 32'h5, 32'h6, 32'h0, 32'h0, 2'd0, 2'd0,
                 1'b1, 5'd0, 32'h99, 1'b1, 1'b0, 5'd0, 32'h0,
                 32'h0, 32'h0, 32'h0);

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    driveInputs(vecs[0]);
    #3;
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_op1", out_operand1, 32'd0);
    checkOutput("rst_op2", out_operand2, 32'd0);
    checkOutput("rst_store", out_store_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], w);
      checkOutput("vec_no_stall", w, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;

    // load-use on rs2: held off while EX holds a load, accepted once it lands in WB
    lu = mk(5'd1, 5'd7, 32'h11, 32'h70, 32'h0, 32'h0, 2'd2, 2'd0,
            1'b1, 5'd7, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0,
            32'h0, 32'h55, 32'h55);
    driveInputs(lu);
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("lu_stall", {31'd0, hazard_stall}, 32'd1);
    checkOutput("lu_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lu_no_capture", {31'd0, out_valid}, 32'd0);
    lu.ex_wr = 1'b0;
    lu.ex_ld = 1'b0;
    lu.wb_wr = 1'b1;
    lu.wb_rd = 5'd7;
    lu.wb_res = 32'h55;
    applyStimulus(lu, w);
    checkOutput("lu_release", w, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // backpressure: entry held while the ALU stalls, then back-to-back captures
    out_ready = 1'b0;
    applyStimulus(vecs[0], w);
    driveInputs(vecs[1]);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_op1_hold", out_operand1, vecs[0].e1);
      checkOutput("bp_op2_hold", out_operand2, vecs[0].e2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(vecs[1], w);
    checkOutput("b2b_first", w, 32'd0);
    applyStimulus(vecs[2], w);
    checkOutput("b2b_second", w, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // asynchronous reset while an entry is waiting
    out_ready = 1'b0;
    applyStimulus(vecs[4], w);
    @(negedge clk);
    checkOutput("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_op1", out_operand1, 32'd0);
    checkOutput("mid_rst_op2", out_operand2, 32'd0);
    checkOutput("mid_rst_store", out_store_data, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    applyStimulus(vecs[6], w);
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    #1;
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
